// File: rtl/axis_pkt_fifo_if.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo_if
// AXI-Stream bundle used on both sides of the packet FIFO.
//   TDATA  : flit payload
//   TVALID : producer has a flit
//   TREADY : consumer can take a flit
//   TLAST  : flit closes its packet
// Handshake: a flit moves on a rising edge where TVALID and TREADY are both 1.
// A producer holding TVALID keeps TDATA/TLAST stable until that edge.
// Modports: master drives the flit, slave drives TREADY.
// ---------------------------------------------------------------------------
interface axis_pkt_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TVALID;
  logic                  TREADY;
  logic                  TLAST;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// axis_pkt_fifo
// Store-and-forward AXI-Stream packet FIFO. A packet becomes visible on the
// output only once its TLAST flit is stored. A packet that cannot fit in the
// buffer is discarded whole and counted, so the FIFO never deadlocks.
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous, active-low reset
//   s          : input stream (slave modport)
//   o          : output stream (master modport)
//   drop       : one-cycle pulse after an oversize packet's last flit is discarded
//   drop_count : saturating count of discarded packets
//   dbg_state  : 1 while discarding an oversize packet
// ---------------------------------------------------------------------------
module axis_pkt_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  axis_pkt_fifo_if.slave         s,
  axis_pkt_fifo_if.master        o,
  output logic                   drop,
  output logic [15:0]            drop_count,
  output logic                   dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] ONE_P   = PW'(1);

  typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

  // Each entry holds {TLAST, TDATA}.
  logic [DATA_WIDTH:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr, rd_ptr, commit_ptr, pkt_cnt, used;
  logic            full;
  logic            s_ready;
  logic            wr_en, rd_en;
  logic            drop_enter, drop_done;
  logic            out_last;
  logic            cnt_inc, cnt_dec;

  // The extra pointer MSB tells a full buffer from an empty one.
  assign used = wr_ptr - rd_ptr;
  assign full = (used == DEPTH_P);

  // Asynchronous read of the oldest stored flit.
  assign out_last = mem[rd_ptr[DEPTH_LOG2-1:0]][DATA_WIDTH];
  assign o.TDATA  = mem[rd_ptr[DEPTH_LOG2-1:0]][DATA_WIDTH-1:0];
  assign o.TLAST  = out_last;
  assign o.TVALID = (pkt_cnt != '0);
  assign rd_en    = o.TVALID && o.TREADY;

  assign dbg_state = (state_q == DROP);

  // Next state and input-side control. TREADY depends only on registered
  // state (and reset), never on the output side.
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    drop_enter = 1'b0;
    drop_done  = 1'b0;
    case (state_q)
      PASS: begin
        s_ready = !full;
        // Buffer full of a single incomplete packet: it can never be sent,
        // so rewind to the last packet boundary and discard the rest of it.
        if (full && (pkt_cnt == '0) && s.TVALID) begin
          state_d    = DROP;
          drop_enter = 1'b1;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        if (s.TVALID && s.TLAST) begin
          state_d   = PASS;
          drop_done = 1'b1;
        end
      end
      default: state_d = PASS;
    endcase
  end

  assign s.TREADY = rst && s_ready;
  assign wr_en    = (state_q == PASS) && s.TVALID && s.TREADY;
  assign cnt_inc  = wr_en && s.TLAST;
  assign cnt_dec  = rd_en && out_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PASS;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
      pkt_cnt    <= '0;
      drop       <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q <= state_d;

      if (drop_enter) begin
        wr_ptr <= commit_ptr;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + ONE_P;
      end

      if (cnt_inc) begin
        commit_ptr <= wr_ptr + ONE_P;
      end

      if (rd_en) begin
        rd_ptr <= rd_ptr + ONE_P;
      end

      case ({cnt_inc, cnt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + ONE_P;
        2'b01:   pkt_cnt <= pkt_cnt - ONE_P;
        default: pkt_cnt <= pkt_cnt;
      endcase

      drop <= drop_done;
      if (drop_done && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s.TLAST, s.TDATA};
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_fifo
// Bench for axis_pkt_fifo with DEPTH_LOG2=3 (8 flits). A queue-based model
// (committed flits, partial packet, discard mode) predicts every output each
// cycle; directed scenarios add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_axis_pkt_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_pkt_fifo_if #(.DATA_WIDTH(DW)) s_if ();
  axis_pkt_fifo_if #(.DATA_WIDTH(DW)) o_if ();

  logic        drop;
  logic [15:0] drop_count;
  logic        dbg_state;

  axis_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .s          (s_if),
    .o          (o_if),
    .drop       (drop),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- counters / check ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DW:0] exp_q[$];   // committed flits {last,data}, oldest first
  logic [DW:0] part_q[$];  // flits of the packet still being received
  bit          m_discard = 0;
  bit          m_drop_ev = 0;
  logic [15:0] m_cnt     = '0;

  function automatic int pkts_in();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i][DW]) n++;
    return n;
  endfunction

  function automatic bit model_ready();
    if (m_discard) return 1'b1;
    return (exp_q.size() + part_q.size()) < DEPTH;
  endfunction

  int m_stored, m_pk;
  bit m_acc, m_rd, m_rdy;
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      part_q.delete();
      m_discard = 0;
      m_drop_ev = 0;
      m_cnt     = '0;
    end else begin
      m_stored  = exp_q.size() + part_q.size();
      m_pk      = pkts_in();
      m_rdy     = model_ready();
      m_acc     = s_if.TVALID && m_rdy;
      m_rd      = (m_pk > 0) && o_if.TREADY;
      m_drop_ev = 0;
      if (m_rd) void'(exp_q.pop_front());
      if (m_discard) begin
        if (m_acc && s_if.TLAST) begin
          m_discard = 0;
          m_drop_ev = 1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
      end else if (m_acc) begin
        part_q.push_back({s_if.TLAST, s_if.TDATA});
        if (s_if.TLAST) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
        end
      end else if (m_stored == DEPTH && m_pk == 0 && s_if.TVALID) begin
        m_discard = 1;
        part_q.delete();
      end
    end
  end

  // ---------------- monitors ----------------
  logic [DW:0] log_q[$];
  logic [DW:0] ref_q[$];
  int drop_seen = 0;
  always @(posedge clk) begin
    if (rst && o_if.TVALID && o_if.TREADY) log_q.push_back({o_if.TLAST, o_if.TDATA});
    if (rst && drop) drop_seen++;
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        chk("rst_s_tready", s_if.TREADY, 0);
        chk("rst_o_tvalid", o_if.TVALID, 0);
        chk("rst_drop", drop, 0);
        chk("rst_drop_count", drop_count, 0);
      end else begin
        chk("s_tready", s_if.TREADY, model_ready());
        chk("o_tvalid", o_if.TVALID, pkts_in() > 0);
        chk("drop", drop, m_drop_ev);
        chk("drop_count", drop_count, m_cnt);
        chk("dbg_state", dbg_state, m_discard);
        if (pkts_in() > 0) begin
          chk("o_tdata", o_if.TDATA, exp_q[0][DW-1:0]);
          chk("o_tlast", o_if.TLAST, exp_q[0][DW]);
        end
      end
    end
  end

  // ---------------- output ready driver ----------------
  bit rand_o = 0;
  bit o_fix  = 0;
  initial begin
    o_if.TREADY = 1'b0;
    forever begin
      @(negedge clk);
      o_if.TREADY = rand_o ? 1'($urandom_range(0, 1)) : o_fix;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns at the falling edge after
  // the flit has been taken.
  task automatic send_flit(input logic [DW-1:0] d, input logic l);
    bit acc;
    int guard = 0;
    s_if.TVALID = 1'b1;
    s_if.TDATA  = d;
    s_if.TLAST  = l;
    forever begin
      #1;
      acc = s_if.TREADY;
      @(negedge clk);
      if (acc) break;
      guard++;
      if (guard > 100) begin
        timeout_fail("send_flit");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_if.TVALID = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int g = 0;
    s_if.TVALID = 1'b0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) timeout_fail("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, log_q.size(), ref_q.size());
    foreach (ref_q[i]) begin
      if (i < log_q.size()) chk(name, log_q[i], ref_q[i]);
    end
    log_q.delete();
    ref_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_if.TVALID = 1'b0;
    s_if.TDATA  = '0;
    s_if.TLAST  = 1'b0;

    // Reset held
    repeat (3) @(negedge clk);
    #1;
    chk("lit_rst_tready", s_if.TREADY, 0);
    chk("lit_rst_tvalid", o_if.TVALID, 0);
    chk("lit_rst_drop_count", drop_count, 0);
    @(negedge clk);
    rst   = 1'b1;
    o_fix = 1'b1;
    repeat (2) @(negedge clk);

    // First packet after reset
    send_flit(32'hA1, 0);
    send_flit(32'hA2, 0);
    send_flit(32'hA3, 1);
    drain();
    ref_q.push_back({1'b0, 32'hA1});
    ref_q.push_back({1'b0, 32'hA2});
    ref_q.push_back({1'b1, 32'hA3});
    chk_log("lit_first_pkt");

    // Store-and-forward hold
    send_flit(32'hB0, 0);
    send_flit(32'hB1, 0);
    s_if.TVALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("lit_sf_hold", o_if.TVALID, 0);
    end
    @(negedge clk);
    send_flit(32'hB2, 1);
    drain();
    ref_q.push_back({1'b0, 32'hB0});
    ref_q.push_back({1'b0, 32'hB1});
    ref_q.push_back({1'b1, 32'hB2});
    chk_log("lit_sf_pkt");

    // Full / backpressure
    o_fix = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) send_flit(32'h30 + i, (i == 3) || (i == 7));
    s_if.TVALID = 1'b0;
    #1;
    chk("lit_full_tready", s_if.TREADY, 0);
    chk("lit_full_tvalid", o_if.TVALID, 1);
    o_fix = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("lit_full_tready_back", s_if.TREADY, 1);
    drain();
    for (int i = 0; i < 8; i++) ref_q.push_back({((i == 3) || (i == 7)) ? 1'b1 : 1'b0, 32'h30 + i});
    chk_log("lit_full_pkts");

    // Boundaries: exactly DEPTH passes, DEPTH+1 is dropped
    for (int i = 0; i < 8; i++) send_flit(32'h40 + i, i == 7);
    drain();
    for (int i = 0; i < 8; i++) ref_q.push_back({(i == 7) ? 1'b1 : 1'b0, 32'h40 + i});
    chk_log("lit_depth_pkt");
    chk("lit_depth_no_drop", drop_seen, 0);
    for (int i = 0; i < 9; i++) send_flit(32'h10 + i, i == 8);
    idle(4);
    #1;
    chk("lit_over_drop_count", drop_count, 1);
    chk("lit_over_drop_pulses", drop_seen, 1);
    chk("lit_over_no_output", log_q.size(), 0);
    @(negedge clk);
    send_flit(32'h20, 0);
    send_flit(32'h21, 1);
    drain();
    ref_q.push_back({1'b0, 32'h20});
    ref_q.push_back({1'b1, 32'h21});
    chk_log("lit_after_drop");

    // Stream of single-flit packets, then reset mid-stream
    for (int i = 0; i < 16; i++) begin
      s_if.TVALID = 1'b1;
      s_if.TDATA  = 32'h50 + i;
      s_if.TLAST  = 1'b1;
      @(negedge clk);
      #1;
      chk("lit_stream_tvalid", o_if.TVALID, 1);
    end
    #1;
    rst = 1'b0;
    #1;
    chk("lit_midrst_tvalid", o_if.TVALID, 0);
    chk("lit_midrst_tready", s_if.TREADY, 0);
    @(negedge clk);
    rst = 1'b1;
    s_if.TVALID = 1'b0;
    log_q.delete();
    @(negedge clk);
    send_flit(32'h60, 0);
    send_flit(32'h61, 1);
    drain();
    ref_q.push_back({1'b0, 32'h60});
    ref_q.push_back({1'b1, 32'h61});
    chk_log("lit_after_midrst");

    // Randomized traffic with random output backpressure
    rand_o = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 11);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send_flit($urandom, j == len - 1);
      end
    end
    drain();
    rand_o = 0;
    o_fix  = 1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound on run time
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

endmodule
